draw_playground_param: RTL and testbench
========================================

# draw_playground_param

Parametrised playground renderer for the VGA pixel pipeline: it overlays the field markings (border lines, centre line, centre-circle ring, both goals) on the incoming background `rgb_in` and passes the timing signals through. Unlike the previous generation, geometry is parameter-driven, the centre circle is drawn through a pipelined squared-distance comparison, and a goal-flash state machine blinks the scoring goal mouth for a set number of frames. It sits between the background generator and the puck/mallet drawing stages.

## Interface
- `H_ACTIVE`, 1024: active pixels per line.
- `V_ACTIVE`, 768: active lines per frame.
- `MARGIN`, 39: distance from the screen edge to the outer field line.
- `LINE_W`, 8: line thickness in pixels. Must be even and ≥2.
- `GOAL_TOP`, 258: first line of the goal posts.
- `GOAL_BOT`, 458: last line of the goal posts.
- `R_IN`, 100: inner radius of the centre ring.
- `R_OUT`, 108: outer radius of the centre ring. Must be greater than `R_IN`.
- `FLASH_FRAMES`, 60: flash duration in frames. Must be ≥1.
- `BLINK_FRAMES`, 8: frames per blink half-period. Must be ≥1.
- `LINE_COLOUR`, 12'hfff: colour of all markings.
- `FLASH_COLOUR`, 12'hf00: colour of the goal mouth while blink is on.
- `clk_in`  in  1  pixel clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hcount_in`, `vcount_in`  in  12  pixel position.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in`  in  1  timing signals.
- `rgb_in`  in  12  background colour.
- `goal_left`, `goal_right`  in  1  single-cycle pulse when a goal is scored in the left or right goal.
- `hcount_out`, `vcount_out`, `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`  out  12/1  inputs delayed by 3 cycles.
- `rgb_out`  out  12  composed colour.
- `flash_active`  out  1  high while the FSM is not in IDLE.

## Operation
- Definitions: `CX = H_ACTIVE/2`, `CY = V_ACTIVE/2`, `dx = hcount - CX`, `dy = vcount - CY`.
  - `dx` and `dy` are 13-bit signed.
  - `dx²` and `dy²` are 24-bit unsigned.
  - The sum is 25-bit unsigned.
- Line regions (ranges inclusive):
  - Left outer line: h∈[MARGIN, MARGIN+LINE_W-1], v∈[MARGIN, V_ACTIVE-MARGIN-1].
  - Right outer line: h∈[H_ACTIVE-MARGIN-LINE_W, H_ACTIVE-MARGIN-1], same v range.
  - Top line: v∈[MARGIN, MARGIN+LINE_W-1], h∈[MARGIN, H_ACTIVE-MARGIN-1].
  - Bottom line: v∈[V_ACTIVE-MARGIN-LINE_W, V_ACTIVE-MARGIN-1], same h range.
  - Centre line: h∈[CX-LINE_W/2, CX+LINE_W/2-1], v within the outer lines.
  - Centre ring: R_IN² ≤ dx²+dy² ≤ R_OUT².
- Goal regions:
  - Left back bar: h∈[0, LINE_W-1], v∈[GOAL_TOP, GOAL_BOT].
  - Left posts: h∈[0, MARGIN], with v∈[GOAL_TOP, GOAL_TOP+LINE_W-1] or v∈[GOAL_BOT-LINE_W+1, GOAL_BOT].
  - The right goal is the horizontal mirror of the left: bar h∈[H_ACTIVE-LINE_W, H_ACTIVE-1], posts h∈[H_ACTIVE-MARGIN-1, H_ACTIVE-1].
- Goal mouth interior, v∈[GOAL_TOP+LINE_W, GOAL_BOT-LINE_W]:
  - Left: h∈[LINE_W, MARGIN-1].
  - Right: h∈[H_ACTIVE-MARGIN, H_ACTIVE-LINE_W-1].
- Colour priority:
  1. Blanking (either `hblnk` or `vblnk`): 12'h000.
  2. Any line or goal region: `LINE_COLOUR`.
  3. Mouth of the flashing goal while `blink_on`: `FLASH_COLOUR`.
  4. Otherwise: `rgb_in`.
- FSM states: IDLE, FLASH_L, FLASH_R.
  - IDLE→FLASH_L on `goal_left`; IDLE→FLASH_R on `goal_right`. If both pulse in the same cycle, `goal_left` wins.
  - On entry: `frame_cnt` = FLASH_FRAMES, `blink_cnt` = 0, `blink_on` = 1.
  - Goal pulses arriving outside IDLE are ignored.
- Frame tick: rising edge of `vsync_in`, detected against a registered copy of `vsync_in`. On each tick in FLASH_x:
  - `frame_cnt` decrements.
  - `blink_cnt` increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and `blink_on` toggles.
  - The tick that takes `frame_cnt` from 1 to 0 returns the FSM to IDLE.

## Timing
- Reset (`rst_n` low, asynchronous):
  - All outputs are 0, including `rgb_out` = 12'h000 and `flash_active` = 0.
  - FSM is IDLE; all counters are 0.
  - Reset mid-flash aborts the flash immediately.
- Pipeline, latency 3 cycles, throughput 1 pixel/clk:
  - Stage 1: register the inputs, `dx`/`dy`, and the region flags.
  - Stage 2: `dx²`, `dy²`.
  - Stage 3: sum, ring compare, colour mux, output register.
- Timing outputs equal their inputs delayed by exactly 3 cycles, aligned with `rgb_out`.
- FSM transitions take effect on the clock edge after the pulse. `flash_active` is registered.
- Stage 3 uses the FSM/blink state current at that cycle.

## Test plan
- Reset → all outputs 0. Release reset, apply h=100, v=100, `rgb_in`=12'h0a0 → `rgb_out`=12'h0a0 and `hcount_out`=100 three cycles later.
- Line pixels h=40,v=100, h=980,v=500, and h=512,v=300 → 12'hfff. The same pixels with `hblnk_in`=1 → 12'h000.
- Ring, v=384: h=612 (dx=100) → fff; h=620 (dx=108) → fff; h=407 (dx=-105) → fff; h=611 → `rgb_in`; h=621 → `rgb_in`.
- Goal geometry: h=3,v=300 and h=30,v=260 → fff; h=1020,v=455 → fff; h=20,v=350 with no flash → `rgb_in`.
- `goal_right` pulse, then frame stimulus with pixel h=1000,v=350:
  - → `flash_active` high; f00 for 8 frames, `rgb_in` for the next 8, alternating.
  - IDLE and `flash_active` low after the 60th vsync edge.
  - A `goal_left` pulse mid-flash is ignored.
- Simultaneous `goal_left` and `goal_right` in IDLE → FLASH_L; pixel h=20,v=350 is f00 on the first frame. Assert `rst_n` during the flash → `flash_active`=0 and `rgb_out`=0 immediately.

Source files
------------

// File: rtl/draw_playground_param.sv
// Purpose : overlays field markings (outer lines, centre line, centre ring, goals) and a blinking goal mouth on rgb_in.
// Latency : 3 clk_in cycles for pixel, colour and timing; throughput one pixel per clock.
// Backpr. : none; free-running pixel pipeline that always accepts one pixel per clock.
// Ports   : clk_in, rst_n (async, active low); hcount/vcount/hsync/vsync/hblnk/vblnk/rgb _in -> same _out delayed 3;
//           goal_left/goal_right single-cycle score pulses; flash_active high while a goal flash is running.
module draw_playground_param #(
  parameter int          H_ACTIVE     = 1024,
  parameter int          V_ACTIVE     = 768,
  parameter int          MARGIN       = 39,
  parameter int          LINE_W       = 8,
  parameter int          GOAL_TOP     = 258,
  parameter int          GOAL_BOT     = 458,
  parameter int          R_IN         = 100,
  parameter int          R_OUT        = 108,
  parameter int          FLASH_FRAMES = 60,
  parameter int          BLINK_FRAMES = 8,
  parameter logic [11:0] LINE_COLOUR  = 12'hfff,
  parameter logic [11:0] FLASH_COLOUR = 12'hf00
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        goal_left,
  input  logic        goal_right,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        flash_active
);

  // Geometry bounds, all inclusive.
  localparam logic [11:0] ZERO  = 12'd0;
  localparam logic [11:0] CX    = 12'(H_ACTIVE / 2);
  localparam logic [11:0] CY    = 12'(V_ACTIVE / 2);
  localparam logic [11:0] OL0   = 12'(MARGIN);
  localparam logic [11:0] OL1   = 12'(MARGIN + LINE_W - 1);
  localparam logic [11:0] OR0   = 12'(H_ACTIVE - MARGIN - LINE_W);
  localparam logic [11:0] OR1   = 12'(H_ACTIVE - MARGIN - 1);
  localparam logic [11:0] OB0   = 12'(V_ACTIVE - MARGIN - LINE_W);
  localparam logic [11:0] OB1   = 12'(V_ACTIVE - MARGIN - 1);
  localparam logic [11:0] CL0   = 12'(H_ACTIVE / 2 - LINE_W / 2);
  localparam logic [11:0] CL1   = 12'(H_ACTIVE / 2 + LINE_W / 2 - 1);
  localparam logic [11:0] GT0   = 12'(GOAL_TOP);
  localparam logic [11:0] GT1   = 12'(GOAL_TOP + LINE_W - 1);
  localparam logic [11:0] GB0   = 12'(GOAL_BOT - LINE_W + 1);
  localparam logic [11:0] GB1   = 12'(GOAL_BOT);
  localparam logic [11:0] MV0   = 12'(GOAL_TOP + LINE_W);
  localparam logic [11:0] MV1   = 12'(GOAL_BOT - LINE_W);
  localparam logic [11:0] LBAR1 = 12'(LINE_W - 1);
  localparam logic [11:0] LPST1 = 12'(MARGIN);
  localparam logic [11:0] RBAR0 = 12'(H_ACTIVE - LINE_W);
  localparam logic [11:0] RPST0 = 12'(H_ACTIVE - MARGIN - 1);
  localparam logic [11:0] HEND  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] LM0   = 12'(LINE_W);
  localparam logic [11:0] LM1   = 12'(MARGIN - 1);
  localparam logic [11:0] RM0   = 12'(H_ACTIVE - MARGIN);
  localparam logic [11:0] RM1   = 12'(H_ACTIVE - LINE_W - 1);
  localparam logic [24:0] RIN2  = 25'(R_IN * R_IN);
  localparam logic [24:0] ROUT2 = 25'(R_OUT * R_OUT);
  localparam int          FW    = $clog2(FLASH_FRAMES + 1);
  localparam int          BW    = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FLASH_L = 2'd1, FLASH_R = 2'd2} state_t;

  function automatic logic in_rng(input logic [11:0] x, input logic [11:0] lo, input logic [11:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

  // ---------------- stage 1: region flags and centre offsets
  logic        mark_c, mouth_l_c, mouth_r_c, v_field, h_field, goal_bar_v, goal_post_v, mouth_v;
  logic [12:0] dx_c, dy_c;

  always_comb begin
    v_field     = in_rng(vcount_in, OL0, OB1);
    h_field     = in_rng(hcount_in, OL0, OR1);
    goal_bar_v  = in_rng(vcount_in, GT0, GB1);
    goal_post_v = in_rng(vcount_in, GT0, GT1) || in_rng(vcount_in, GB0, GB1);
    mouth_v     = in_rng(vcount_in, MV0, MV1);
    mark_c      = (v_field && (in_rng(hcount_in, OL0, OL1) || in_rng(hcount_in, OR0, OR1) ||
                               in_rng(hcount_in, CL0, CL1)))
               || (h_field && (in_rng(vcount_in, OL0, OL1) || in_rng(vcount_in, OB0, OB1)))
               || (goal_bar_v && (in_rng(hcount_in, ZERO, LBAR1) || in_rng(hcount_in, RBAR0, HEND)))
               || (goal_post_v && (in_rng(hcount_in, ZERO, LPST1) || in_rng(hcount_in, RPST0, HEND)));
    mouth_l_c   = mouth_v && in_rng(hcount_in, LM0, LM1);
    mouth_r_c   = mouth_v && in_rng(hcount_in, RM0, RM1);
    dx_c        = {1'b0, hcount_in} - {1'b0, CX};
    dy_c        = {1'b0, vcount_in} - {1'b0, CY};
  end

  logic [11:0] s1_h, s1_v, s1_rgb, s2_h, s2_v, s2_rgb;
  logic        s1_hs, s1_vs, s1_hb, s1_vb, s1_mark, s1_ml, s1_mr;
  logic        s2_hs, s2_vs, s2_hb, s2_vb, s2_mark, s2_ml, s2_mr;
  logic [12:0] s1_dx, s1_dy;
  logic [23:0] s2_dx2, s2_dy2;

  // ---------------- stage 2 helpers: magnitude of the signed offsets (|dx| < 4096 for any 12-bit input)
  logic [11:0] dx_abs, dy_abs;
  always_comb begin
    dx_abs = s1_dx[12] ? (~s1_dx[11:0] + 12'd1) : s1_dx[11:0];
    dy_abs = s1_dy[12] ? (~s1_dy[11:0] + 12'd1) : s1_dy[11:0];
  end

  // ---------------- flash FSM
  state_t          state;
  logic [FW-1:0]   frame_cnt;
  logic [BW-1:0]   blink_cnt;
  logic            blink_on, vsync_q, frame_tick;

  assign frame_tick = vsync_in & ~vsync_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      blink_cnt    <= '0;
      blink_on     <= 1'b0;
      vsync_q      <= 1'b0;
      flash_active <= 1'b0;
    end else begin
      vsync_q <= vsync_in;
      case (state)
        IDLE: begin
          if (goal_left || goal_right) begin
            state        <= goal_left ? FLASH_L : FLASH_R;   // left wins a tie
            frame_cnt    <= FW'(FLASH_FRAMES);
            blink_cnt    <= '0;
            blink_on     <= 1'b1;
            flash_active <= 1'b1;
          end
        end
        default: begin
          if (frame_tick) begin
            if (frame_cnt == FW'(1)) begin
              state        <= IDLE;
              frame_cnt    <= '0;
              blink_cnt    <= '0;
              blink_on     <= 1'b0;
              flash_active <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt - FW'(1);
              if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
              end else begin
                blink_cnt <= blink_cnt + BW'(1);
              end
            end
          end
        end
      endcase
    end
  end

  // ---------------- stage 3: ring compare and colour priority, using the FSM state of this cycle
  logic [24:0] sq_sum;
  logic        ring, flash_px;
  logic [11:0] rgb_nxt;

  always_comb begin
    sq_sum   = {1'b0, s2_dx2} + {1'b0, s2_dy2};
    ring     = (sq_sum >= RIN2) && (sq_sum <= ROUT2);
    flash_px = blink_on && (((state == FLASH_L) && s2_ml) || ((state == FLASH_R) && s2_mr));
    if (s2_hb || s2_vb)       rgb_nxt = 12'h000;
    else if (s2_mark || ring) rgb_nxt = LINE_COLOUR;
    else if (flash_px)        rgb_nxt = FLASH_COLOUR;
    else                      rgb_nxt = s2_rgb;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      {s1_h, s1_v, s1_rgb, s1_hs, s1_vs, s1_hb, s1_vb, s1_mark, s1_ml, s1_mr} <= '0;
      s1_dx <= '0;
      s1_dy <= '0;
      {s2_h, s2_v, s2_rgb, s2_hs, s2_vs, s2_hb, s2_vb, s2_mark, s2_ml, s2_mr} <= '0;
      s2_dx2 <= '0;
      s2_dy2 <= '0;
      {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} <= '0;
    end else begin
      s1_h    <= hcount_in;  s1_v  <= vcount_in;  s1_rgb <= rgb_in;
      s1_hs   <= hsync_in;   s1_vs <= vsync_in;   s1_hb  <= hblnk_in;  s1_vb <= vblnk_in;
      s1_mark <= mark_c;     s1_ml <= mouth_l_c;  s1_mr  <= mouth_r_c;
      s1_dx   <= dx_c;       s1_dy <= dy_c;

      s2_h    <= s1_h;       s2_v  <= s1_v;       s2_rgb <= s1_rgb;
      s2_hs   <= s1_hs;      s2_vs <= s1_vs;      s2_hb  <= s1_hb;     s2_vb <= s1_vb;
      s2_mark <= s1_mark;    s2_ml <= s1_ml;      s2_mr  <= s1_mr;
      s2_dx2  <= {12'd0, dx_abs} * {12'd0, dx_abs};
      s2_dy2  <= {12'd0, dy_abs} * {12'd0, dy_abs};

      hcount_out <= s2_h;    vcount_out <= s2_v;
      hsync_out  <= s2_hs;   vsync_out  <= s2_vs;
      hblnk_out  <= s2_hb;   vblnk_out  <= s2_vb;
      rgb_out    <= rgb_nxt;
    end
  end

endmodule

// File: tb/tb_draw_playground_param.sv
// Purpose : self-checking bench for draw_playground_param against a frame/geometry reference model.
// Latency : model expects every output 3 clocks after its pixel, coloured with the flash state of the last stage.
// Backpr. : none; one pixel driven per clock.
module tb_draw_playground_param;

  localparam int H = 1024, V = 768, M = 39, LW = 8, GT = 258, GB = 458;
  localparam int RI = 100, RO = 108, FF = 60, BF = 8;
  localparam logic [11:0] LC = 12'hfff, FC = 12'hf00;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [11:0] hcount_in, vcount_in, rgb_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in, goal_left, goal_right;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out, flash_active;

  draw_playground_param #(
    .H_ACTIVE(H), .V_ACTIVE(V), .MARGIN(M), .LINE_W(LW), .GOAL_TOP(GT), .GOAL_BOT(GB),
    .R_IN(RI), .R_OUT(RO), .FLASH_FRAMES(FF), .BLINK_FRAMES(BF),
    .LINE_COLOUR(LC), .FLASH_COLOUR(FC)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .goal_left(goal_left), .goal_right(goal_right),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .flash_active(flash_active)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        vld;
    logic [11:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } pix_t;

  pix_t pipe [3];
  int   m_side;      // 0 none, 1 left goal flashing, 2 right goal flashing
  int   m_ticks;     // frame ticks seen since the flash started
  bit   m_prev_vs;
  int   n_cmp = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_r(int x, int lo, int hi);
    return (x >= lo) && (x <= hi);
  endfunction

  // Goal shapes described for the left goal; the right goal is checked with hm = H-1-h.
  function automatic bit goal_at(int hm, int v);
    return (in_r(hm, 0, LW - 1) && in_r(v, GT, GB)) ||
           (in_r(hm, 0, M) && (in_r(v, GT, GT + LW - 1) || in_r(v, GB - LW + 1, GB)));
  endfunction

  function automatic bit mouth_at(int hm, int v);
    return in_r(hm, LW, M - 1) && in_r(v, GT + LW, GB - LW);
  endfunction

  function automatic bit blink_now();
    return ((m_ticks / BF) % 2) == 0;
  endfunction

  function automatic int ref_rgb(pix_t p, int side, bit blink);
    int h, v, dx, dy, d2;
    bit mark;
    if (!p.vld) return 0;
    if (p.hb || p.vb) return 0;
    h = int'(p.h);
    v = int'(p.v);
    mark = 0;
    if (in_r(v, M, V - M - 1) && (in_r(h, M, M + LW - 1) || in_r(h, H - M - LW, H - M - 1) ||
                                  in_r(h, H / 2 - LW / 2, H / 2 + LW / 2 - 1))) mark = 1;
    if (in_r(h, M, H - M - 1) && (in_r(v, M, M + LW - 1) || in_r(v, V - M - LW, V - M - 1))) mark = 1;
    dx = h - H / 2;
    dy = v - V / 2;
    d2 = dx * dx + dy * dy;
    if (d2 >= RI * RI && d2 <= RO * RO) mark = 1;
    if (goal_at(h, v) || goal_at(H - 1 - h, v)) mark = 1;
    if (mark) return int'(LC);
    if (blink && ((side == 1 && mouth_at(h, v)) || (side == 2 && mouth_at(H - 1 - h, v)))) return int'(FC);
    return int'(p.rgb);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_side = 0;
    m_ticks = 0;
    m_prev_vs = 0;
  endtask

  // One clock: advance the model with the inputs the DUT sampled, then check all outputs.
  task automatic cycle();
    pix_t cur;
    int   exp_rgb;
    @(posedge clk_in);
    if (!rst_n) begin
      model_reset();
      exp_rgb = 0;
    end else begin
      cur = '{vld: 1'b1, h: hcount_in, v: vcount_in, hs: hsync_in, vs: vsync_in,
              hb: hblnk_in, vb: vblnk_in, rgb: rgb_in};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = cur;
      exp_rgb = ref_rgb(pipe[2], m_side, blink_now());
      if (m_side == 0) begin
        if (goal_left)       begin m_side = 1; m_ticks = 0; end
        else if (goal_right) begin m_side = 2; m_ticks = 0; end
      end else if (vsync_in && !m_prev_vs) begin
        m_ticks++;
        if (m_ticks == FF) m_side = 0;
      end
      m_prev_vs = vsync_in;
    end
    #1;
    check_eq("rgb_out", rgb_out, exp_rgb);
    check_eq("hcount_out", hcount_out, pipe[2].h);
    check_eq("vcount_out", vcount_out, pipe[2].v);
    check_eq("sync_blank_out", {hsync_out, vsync_out, hblnk_out, vblnk_out},
             {pipe[2].hs, pipe[2].vs, pipe[2].hb, pipe[2].vb});
    check_eq("flash_active", flash_active, m_side != 0);
  endtask

  task automatic px_expect(input string tag, input int h, input int v, input int rgb,
                           input bit hb, input logic [11:0] exp);
    hcount_in = 12'(h);
    vcount_in = 12'(v);
    rgb_in    = 12'(rgb);
    hblnk_in  = hb;
    vblnk_in  = 1'b0;
    repeat (3) cycle();
    check_eq(tag, rgb_out, exp);
  endtask

  initial begin
    logic [11:0] frgb, fexp;
    rst_n = 1'b0;
    {hcount_in, vcount_in, rgb_in} = '0;
    {hsync_in, vsync_in, hblnk_in, vblnk_in, goal_left, goal_right} = '0;
    model_reset();

    // reset state
    repeat (3) cycle();
    check_eq("reset_rgb", rgb_out, 12'h000);
    check_eq("reset_flash", flash_active, 1'b0);

    // first pixel after reset
    hcount_in = 12'd100; vcount_in = 12'd100; rgb_in = 12'h0a0;
    rst_n = 1'b1;
    repeat (3) cycle();
    check_eq("first_rgb", rgb_out, 12'h0a0);
    check_eq("first_hcount", hcount_out, 12'd100);

    // lines, blanking, ring edges, goal geometry
    px_expect("line_left",    40, 100, 12'h123, 0, 12'hfff);
    px_expect("line_right",  980, 500, 12'h123, 0, 12'hfff);
    px_expect("line_centre", 512, 300, 12'h123, 0, 12'hfff);
    px_expect("blank_left",   40, 100, 12'h123, 1, 12'h000);
    px_expect("blank_right", 980, 500, 12'h123, 1, 12'h000);
    px_expect("blank_centre",512, 300, 12'h123, 1, 12'h000);
    px_expect("ring_in",     612, 384, 12'h0b1, 0, 12'hfff);
    px_expect("ring_out",    620, 384, 12'h0b1, 0, 12'hfff);
    px_expect("ring_neg",    407, 384, 12'h0b1, 0, 12'hfff);
    px_expect("ring_below",  611, 384, 12'h0b1, 0, 12'h0b1);
    px_expect("ring_above",  621, 384, 12'h0b1, 0, 12'h0b1);
    px_expect("goal_bar_l",    3, 300, 12'h0b1, 0, 12'hfff);
    px_expect("goal_post_l",  30, 260, 12'h0b1, 0, 12'hfff);
    px_expect("goal_bar_r", 1020, 455, 12'h0b1, 0, 12'hfff);
    px_expect("mouth_idle",   20, 350, 12'h0b1, 0, 12'h0b1);

    // right goal flash, with an ignored left pulse at frame 20
    goal_right = 1'b1;
    cycle();
    goal_right = 1'b0;
    check_eq("flash_start", flash_active, 1'b1);
    hcount_in = 12'd1000; vcount_in = 12'd350;
    for (int f = 0; f <= 61; f++) begin
      frgb = {4'h0, 8'($urandom)};
      rgb_in = frgb;
      for (int c = 0; c < 16; c++) begin
        vsync_in  = (c >= 12);
        goal_left = (f == 20 && c == 2);
        cycle();
        if (c == 8 && (f == 0 || f == 7 || f == 8 || f == 15 || f == 16 || f == 21 || f == 59 || f == 60)) begin
          fexp = (f < FF && (f % 16) < 8) ? FC : frgb;
          check_eq($sformatf("flash_f%0d", f), rgb_out, fexp);
          check_eq($sformatf("flash_act_f%0d", f), flash_active, f < FF);
        end
      end
    end
    goal_left = 1'b0;
    vsync_in  = 1'b0;

    // simultaneous pulses: left wins, then reset aborts the flash
    goal_left = 1'b1; goal_right = 1'b1;
    cycle();
    goal_left = 1'b0; goal_right = 1'b0;
    check_eq("tie_flash", flash_active, 1'b1);
    px_expect("tie_left_mouth", 20, 350, 12'h0a0, 0, 12'hf00);
    px_expect("tie_right_mouth", 1000, 350, 12'h0a0, 0, 12'h0a0);
    rst_n = 1'b0;
    #1;
    check_eq("abort_flash", flash_active, 1'b0);
    check_eq("abort_rgb", rgb_out, 12'h000);
    repeat (2) cycle();
    rst_n = 1'b1;

    // randomized frames with occasional goals, blanking and biased pixel positions
    for (int f = 0; f < 150; f++) begin
      for (int c = 0; c < 16; c++) begin
        vsync_in   = (c >= 12);
        goal_left  = ($urandom_range(0, 199) == 0);
        goal_right = ($urandom_range(0, 199) == 0);
        hsync_in   = 1'($urandom);
        hblnk_in   = ($urandom_range(0, 7) == 0);
        vblnk_in   = ($urandom_range(0, 7) == 0);
        rgb_in     = 12'($urandom);
        case ($urandom_range(0, 3))
          0: begin hcount_in = 12'($urandom_range(0, 1023)); vcount_in = 12'($urandom_range(0, 767)); end
          1: begin hcount_in = 12'($urandom_range(400, 624)); vcount_in = 12'($urandom_range(270, 498)); end
          2: begin
               hcount_in = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 50)) : 12'($urandom_range(973, 1023));
               vcount_in = 12'($urandom_range(240, 476));
             end
          default: begin
               hcount_in = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(500, 525)) : 12'($urandom_range(960, 995));
               vcount_in = 12'($urandom_range(0, 767));
             end
        endcase
        cycle();
      end
    end
    goal_left = 1'b0; goal_right = 1'b0;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
